universal_register: RTL
=======================

# universal_register

Parametrised, positive-edge-triggered storage register: the successor to the single-bit master-slave D flip-flop. It holds a WIDTH-bit word and, on each rising edge of `clock`, performs one of eight modes: hold, parallel load, clear, logical shift left/right, rotate left/right, arithmetic shift right. It adds a synchronous active-low reset to a programmable value. It is the general state element for datapath registers, serial-to-parallel and parallel-to-serial conversion, and small shift-based counters.

## Interface
Parameters:
- `WIDTH`, default 8: word width in bits, ≥ 2.
- `RESET_VALUE`, default 0: WIDTH-bit value loaded by reset.

Ports:
- `clock` input 1: sole clock. All state changes occur on its rising edge.
- `reset_n` input 1: synchronous, active-low reset, sampled on the rising edge of `clock`.
- `enable` input 1: when low, the register holds regardless of `mode`.
- `mode` input 3: operation select, encoding below.
- `d` input WIDTH: parallel load data.
- `serial_in_left` input 1: bit entering at the MSB on SHR.
- `serial_in_right` input 1: bit entering at the LSB on SHL.
- `q` output WIDTH: current register contents.
- `serial_out_left` output 1: equals `q[WIDTH-1]`.
- `serial_out_right` output 1: equals `q[0]`.

## Operation
- Mode encoding: 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 ASR, 7 CLEAR.
- Next-state priority, evaluated each rising edge:
  1. `reset_n`==0: q ← RESET_VALUE.
  2. `enable`==0: q ← q.
  3. Otherwise, by `mode`:
     - HOLD: q ← q.
     - LOAD: q ← d.
     - SHL: q ← {q[WIDTH-2:0], serial_in_right}.
     - SHR: q ← {serial_in_left, q[WIDTH-1:1]}.
     - ROL: q ← {q[WIDTH-2:0], q[WIDTH-1]}.
     - ROR: q ← {q[0], q[WIDTH-1:1]}.
     - ASR: q ← {q[WIDTH-1], q[WIDTH-1:1]}.
     - CLEAR: q ← 0. This is independent of RESET_VALUE.
- Serial outputs are combinational taps of `q`. They have no separate state.
- All modes are pure bit moves. There is no arithmetic, carry or overflow. Bits shifted out are lost, apart from appearing on the serial outputs during the preceding cycle.

## Timing
- One-cycle latency: inputs sampled at edge N are visible on `q` after edge N.
- No combinational path from any input to any output.
- Reset is synchronous only. Asserting `reset_n` between edges has no effect until the next rising edge. Releasing it mid-cycle lets the operation sampled at the next edge proceed normally.
- Reset overrides `enable` and `mode` in the same cycle.
- `q` is undefined from power-up until the first edge with `reset_n`==0. The bench applies reset before checking anything.
- Mode changes take effect at the next edge. No settling cycle is needed, so back-to-back differing modes are legal.
- Shift and rotate by WIDTH consecutive cycles:
  - ROL or ROR returns the original word.
  - SHL with `serial_in_right`=0 yields 0.
  - ASR yields all copies of the original MSB.

## Structure
- Package `universal_register_pkg`:
  - `mode_t`, a 3-bit enum with values MODE_HOLD through MODE_CLEAR in the encoding above.
  - Localparam `MODE_W` = 3.
- Sub-module `dff_cell`: 1-bit rising-edge flip-flop.
  - Ports `clock`, `reset_n`, `reset_value`, `d`, `q`.
  - Synchronous active-low reset to `reset_value`.
  - Instantiated WIDTH times by a generate loop.
- The top level contains only the per-bit next-state multiplexer, which includes the enable gating, plus the serial taps.

## Test plan
- Reset: WIDTH=8, RESET_VALUE=8'hA5, `reset_n`=0 for one edge with mode=LOAD and d=8'hFF → q=8'hA5. Deasserting reset and holding → q stays 8'hA5.
- Load/enable: LOAD d=8'h3C → q=8'h3C. With `enable`=0 and mode=LOAD d=8'hC3 → q stays 8'h3C. Then CLEAR → q=8'h00.
- Shifts: from q=8'h81:
  - SHL with serial_in_right=1 → 8'h03.
  - From 8'h81, SHR with serial_in_left=0 → 8'h40.
  - From 8'h81, ASR → 8'hC0.
  - In each case the serial outputs match q[7] and q[0] each cycle.
- Rotation: q=8'h96, ROL ×8 → 8'h96. Intermediate value after 1 edge = 8'h2D. Same check for ROR, with 8'h4B after 1 edge.
- Serial conversion: shift in 8'b1011_0010 MSB-first via SHL over 8 edges → q=8'hB2. Then SHL ×8 → serial_out_left emits 1,0,1,1,0,0,1,0.
- Reset mid-operation and parameter sweep: assert `reset_n`=0 during a ROL sequence → q=RESET_VALUE at that edge, and ROL resumes from RESET_VALUE after release. Repeat the random-mode reference-model comparison at WIDTH=2 and WIDTH=32.

Source files
------------

// File: rtl/universal_register_pkg.sv
// Shared mode encoding and the per-bit next-state selector used by universal_register.
package universal_register_pkg;

   localparam int MODE_W = 3;

   typedef enum logic [MODE_W-1:0] {
      MODE_HOLD  = 3'd0,
      MODE_LOAD  = 3'd1,
      MODE_SHL   = 3'd2,
      MODE_SHR   = 3'd3,
      MODE_ROL   = 3'd4,
      MODE_ROR   = 3'd5,
      MODE_ASR   = 3'd6,
      MODE_CLEAR = 3'd7
   } mode_t;

   // Each candidate source is already the bit that would land in this position for that mode.
   function automatic logic next_bit(
      input mode_t m,
      input logic  cur_bit,
      input logic  load_bit,
      input logic  shl_bit,
      input logic  shr_bit,
      input logic  rol_bit,
      input logic  ror_bit,
      input logic  asr_bit
   );
      logic nb;
      nb = cur_bit;
      case (m)
         MODE_HOLD:  nb = cur_bit;
         MODE_LOAD:  nb = load_bit;
         MODE_SHL:   nb = shl_bit;
         MODE_SHR:   nb = shr_bit;
         MODE_ROL:   nb = rol_bit;
         MODE_ROR:   nb = ror_bit;
         MODE_ASR:   nb = asr_bit;
         MODE_CLEAR: nb = 1'b0;
         default:    nb = cur_bit;
      endcase
      return nb;
   endfunction

endpackage

// File: rtl/universal_register_dff_cell.sv
// Single-bit rising-edge storage cell with synchronous active-low reset to a per-bit value.
module dff_cell (
   input  logic clock,
   input  logic reset_n,
   input  logic reset_value,
   input  logic d,
   output logic q
);

   logic q_q;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         q_q <= reset_value;
      end else begin
         q_q <= d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/universal_register.sv
// WIDTH-bit register with hold/load/clear/shift/rotate modes built from dff_cell bits.
module universal_register
   import universal_register_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              enable,
   input  logic [MODE_W-1:0] mode,
   input  logic [WIDTH-1:0]  d,
   input  logic              serial_in_left,
   input  logic              serial_in_right,
   output logic [WIDTH-1:0]  q,
   output logic              serial_out_left,
   output logic              serial_out_right
);

   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] shl_src;
   logic [WIDTH-1:0] shr_src;
   logic [WIDTH-1:0] rol_src;
   logic [WIDTH-1:0] ror_src;
   logic [WIDTH-1:0] asr_src;
   mode_t            mode_sel;

   assign mode_sel = mode_t'(mode);

   // Neighbour words: bit i of each holds what position i receives in that mode.
   assign shl_src = {q_q[WIDTH-2:0], serial_in_right};
   assign shr_src = {serial_in_left, q_q[WIDTH-1:1]};
   assign rol_src = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
   assign ror_src = {q_q[0], q_q[WIDTH-1:1]};
   assign asr_src = {q_q[WIDTH-1], q_q[WIDTH-1:1]};

   always_comb begin
      q_d = q_q;
      for (int i = 0; i < WIDTH; i++) begin
         if (enable) begin
            q_d[i] = next_bit(mode_sel, q_q[i], d[i], shl_src[i], shr_src[i],
                              rol_src[i], ror_src[i], asr_src[i]);
         end
      end
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      dff_cell u_cell (
         .clock       (clock),
         .reset_n     (reset_n),
         .reset_value (RESET_VALUE[g]),
         .d           (q_d[g]),
         .q           (q_q[g])
      );
   end

   assign q                = q_q;
   assign serial_out_left  = q_q[WIDTH-1];
   assign serial_out_right = q_q[0];

endmodule
